// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory.
// The arbiter connects through the slave modport; the core and memory
// environment connect through the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  // Instruction-fetch port
  logic                  inst_req_valid;
  logic                  inst_req_ready;
  logic [ADDR_WIDTH-1:0] inst_req_addr;
  logic                  inst_flush;
  logic                  inst_resp_valid;
  logic [31:0]           inst_resp_data;

  // EX-stage data port
  logic                  data_req_valid;
  logic                  data_req_ready;
  logic [ADDR_WIDTH-1:0] data_req_addr;
  logic                  data_req_wen;
  logic [DATA_WIDTH-1:0] data_req_wdata;
  logic [7:0]            data_req_wmask;
  logic                  data_resp_valid;
  logic [DATA_WIDTH-1:0] data_resp_rdata;

  // Shared memory port
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [7:0]            mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport slave (
    input  inst_req_valid, inst_req_addr, inst_flush,
    input  data_req_valid, data_req_addr, data_req_wen, data_req_wdata, data_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output inst_req_ready, inst_resp_valid, inst_resp_data,
    output data_req_ready, data_resp_valid, data_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output inst_req_valid, inst_req_addr, inst_flush,
    output data_req_valid, data_req_addr, data_req_wen, data_req_wdata, data_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  inst_req_ready, inst_resp_valid, inst_resp_data,
    input  data_req_ready, data_resp_valid, data_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter shared by instruction fetch and the EX-stage
// data port. Data has fixed priority over fetch, except that once a waiting
// fetch has been passed over STARVE_LIMIT times in a row it is granted next.
// One transaction is outstanding at a time: IDLE -> REQ -> RESP -> IDLE.
// A flush during an owned fetch lets the memory handshake finish but hides
// the response from the fetch stage. DATA_WIDTH must be 64 and STARVE_LIMIT
// must lie in 1..15 (the starvation counter is four bits wide).
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state,  w_state_nxt;
  owner_t     r_owner,  w_owner_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       r_drop,   w_drop_nxt;
  logic       r_addr2,  w_addr2_nxt;

  logic                  w_grant_data;
  logic                  w_grant_inst;
  logic                  w_fetch_blocked;
  logic [3:0]            w_starve_inc;

  logic                  w_mem_req_valid;
  logic [ADDR_WIDTH-1:0] w_mem_req_addr;
  logic                  w_mem_req_wen;
  logic [DATA_WIDTH-1:0] w_mem_req_wdata;
  logic [7:0]            w_mem_req_wmask;
  logic                  w_inst_req_ready;
  logic                  w_data_req_ready;
  logic                  w_inst_resp_valid;
  logic                  w_data_resp_valid;

  // A waiting fetch that has hit the starvation limit blocks the data port;
  // a fetch is never granted while a flush is asserted.
  assign w_fetch_blocked = bus.inst_req_valid && (r_starve == LIMIT);
  assign w_grant_data    = bus.data_req_valid && !w_fetch_blocked;
  assign w_grant_inst    = !w_grant_data && bus.inst_req_valid && !bus.inst_flush;
  assign w_starve_inc    = (r_starve == LIMIT) ? LIMIT : (r_starve + 4'd1);

  // State, owner and bookkeeping registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_NONE;
      r_starve <= 4'd0;
      r_drop   <= 1'b0;
      r_addr2  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
      r_drop   <= w_drop_nxt;
      r_addr2  <= w_addr2_nxt;
    end
  end

  // Next-state decision and combinational handshake routing.
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_starve_nxt      = r_starve;
    w_drop_nxt        = r_drop;
    w_addr2_nxt       = r_addr2;
    w_mem_req_valid   = 1'b0;
    w_mem_req_addr    = '0;
    w_mem_req_wen     = 1'b0;
    w_mem_req_wdata   = '0;
    w_mem_req_wmask   = 8'h00;
    w_inst_req_ready  = 1'b0;
    w_data_req_ready  = 1'b0;
    w_inst_resp_valid = 1'b0;
    w_data_resp_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          w_state_nxt  = S_REQ;
          w_owner_nxt  = OWN_DATA;
          w_addr2_nxt  = bus.data_req_addr[2];
          w_drop_nxt   = 1'b0;
          // Only grants that pass over a waiting fetch count toward starvation.
          w_starve_nxt = bus.inst_req_valid ? w_starve_inc : 4'd0;
        end else if (w_grant_inst) begin
          w_state_nxt  = S_REQ;
          w_owner_nxt  = OWN_INST;
          w_addr2_nxt  = bus.inst_req_addr[2];
          w_drop_nxt   = 1'b0;
          w_starve_nxt = 4'd0;
        end else if (!bus.inst_req_valid) begin
          w_starve_nxt = 4'd0;
        end
      end

      S_REQ: begin
        // Grant is locked here until memory accepts.
        w_mem_req_valid = 1'b1;
        if (r_owner == OWN_DATA) begin
          w_mem_req_addr   = bus.data_req_addr;
          w_mem_req_wen    = bus.data_req_wen;
          w_mem_req_wdata  = bus.data_req_wdata;
          w_mem_req_wmask  = bus.data_req_wmask;
          w_data_req_ready = bus.mem_req_ready;
        end else begin
          w_mem_req_addr   = bus.inst_req_addr;
          w_inst_req_ready = bus.mem_req_ready;
          if (bus.inst_flush) begin
            w_drop_nxt = 1'b1;
          end
        end
        if (bus.mem_req_ready) begin
          w_state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt = S_IDLE;
          w_owner_nxt = OWN_NONE;
          w_drop_nxt  = 1'b0;
          if (r_owner == OWN_DATA) begin
            w_data_resp_valid = 1'b1;
          end else begin
            // A flush landing on the response cycle also discards it.
            w_inst_resp_valid = !r_drop && !bus.inst_flush;
          end
        end else if ((r_owner == OWN_INST) && bus.inst_flush) begin
          w_drop_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign bus.mem_req_valid   = w_mem_req_valid;
  assign bus.mem_req_addr    = w_mem_req_addr;
  assign bus.mem_req_wen     = w_mem_req_wen;
  assign bus.mem_req_wdata   = w_mem_req_wdata;
  assign bus.mem_req_wmask   = w_mem_req_wmask;
  assign bus.inst_req_ready  = w_inst_req_ready;
  assign bus.data_req_ready  = w_data_req_ready;
  assign bus.inst_resp_valid = w_inst_resp_valid;
  assign bus.data_resp_valid = w_data_resp_valid;
  assign bus.data_resp_rdata = bus.mem_resp_rdata;
  assign bus.inst_resp_data  = r_addr2 ? bus.mem_resp_rdata[63:32] : bus.mem_resp_rdata[31:0];

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch port (read-only, 32-bit instructions) and the EX-stage data port (loads and stores). It is a three-state FSM with fixed data-over-instruction priority and a starvation limit that guarantees fetch progress. It also handles pipeline flushes by discarding in-flight fetch responses. It sits between the core's IF/EX stages and the memory model, replacing their separate direct connections.

Parameters:
ADDR_WIDTH, 64, byte address width.
DATA_WIDTH, 64, memory data width; must be 64.
STARVE_LIMIT, 4, maximum consecutive data grants while a fetch waits; range 1..15.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
inst_req_valid  input  1  fetch request; must hold stable until inst_req_ready
inst_req_ready  output  1  fetch request accepted this cycle
inst_req_addr  input  ADDR_WIDTH  fetch address, 4-byte aligned
inst_flush  input  1  pipeline flush; discard any outstanding fetch response
inst_resp_valid  output  1  fetch data valid, 1-cycle pulse
inst_resp_data  output  32  fetched instruction
data_req_valid  input  1  load/store request; must hold stable until data_req_ready
data_req_ready  output  1  data request accepted this cycle
data_req_addr  input  ADDR_WIDTH  data address
data_req_wen  input  1  1 = store, 0 = load
data_req_wdata  input  DATA_WIDTH  store data
data_req_wmask  input  8  store byte mask
data_resp_valid  output  1  load data / store ack, 1-cycle pulse
data_resp_rdata  output  DATA_WIDTH  load data (raw memory word)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_WIDTH  memory address
mem_req_wen  output  1  write enable
mem_req_wdata  output  DATA_WIDTH  write data
mem_req_wmask  output  8  write byte mask (0 for fetches)
mem_resp_valid  input  1  memory response, 1-cycle pulse, one per accepted request
mem_resp_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset:
  - Outputs: all valid/ready outputs 0, FSM = IDLE, owner = none.
  - Internal state: starve_cnt = 0, drop flag = 0, latched addr bit 2 = 0.
  - rst mid-transaction abandons it; the memory is reset by the same rst.
- States: IDLE, REQ, RESP. At most one transaction is outstanding.
- IDLE:
  - No request presented: stay in IDLE.
  - Grant to data if data_req_valid and not (inst_req_valid and starve_cnt == STARVE_LIMIT); otherwise grant to inst if inst_req_valid and not inst_flush.
  - Register owner and the owner's addr[2], then go to REQ.
  - mem_req_valid = 0 in IDLE.
- REQ:
  - mem_req_valid = 1; mem_req_* driven combinationally from the owner's inputs.
  - Fetches drive wen = 0, wmask = 0, wdata = 0.
  - Owner's *_req_ready = mem_req_ready; the other port's ready = 0.
  - On mem_req_ready go to RESP; otherwise hold with owner unchanged (grant is locked).
- RESP:
  - mem_req_valid = 0.
  - On mem_resp_valid, pulse the owner's *_resp_valid in the same cycle (combinational pass-through), then go to IDLE.
  - Owner data: data_resp_rdata = mem_resp_rdata; inst_resp_data = latched addr[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0].
- Minimum latency: request seen in cycle 0 → mem_req_valid in cycle 1 → response earliest in cycle 2. Back-to-back transactions have a one-cycle IDLE gap.
- Starvation counter:
  - On a data grant while inst_req_valid = 1: starve_cnt++, saturating at STARVE_LIMIT.
  - On an inst grant, or in IDLE with inst_req_valid = 0: starve_cnt = 0.
- Flush:
  - inst_flush while inst owns REQ or RESP sets the drop flag.
  - The downstream handshake still completes, but inst_resp_valid is suppressed for that response; the drop flag clears on that mem_resp_valid.
  - inst_flush in the same cycle as mem_resp_valid also suppresses the response.
  - inst_flush has no effect on a data-owned transaction.
- Outside an owned handshake, *_resp_valid = 0 and *_req_ready = 0.
- mem_resp_valid in IDLE or REQ is a protocol error: ignore it (bench assertion).

Test Plan:
1. Fetch only, inst_req_addr = 0x80000004, mem_req_ready tied 1, mem_resp_valid 1 cycle after accept, rdata = 0x00100073_00000013 → mem_req_valid in cycle 1, inst_resp_valid in cycle 2, inst_resp_data = 0x00100073.
2. Simultaneous inst and data requests, store addr 0x80001000, wdata 0x11, wmask 0x01 → data granted first: mem_req_wen = 1, wmask = 0x01, data_resp_valid ack. The fetch is then granted and completes with inst_resp_valid.
3. Starvation, STARVE_LIMIT = 4: data_req_valid held high for 10 back-to-back loads, inst_req_valid held high → exactly 4 data grants, then 1 inst grant, then data resumes; starve_cnt returns to 0.
4. Flush: fetch accepted, inst_flush pulsed while in RESP, mem_resp_valid 3 cycles later → no inst_resp_valid pulse; FSM returns to IDLE; the next fetch completes normally.
5. Backpressure: mem_req_ready low for 5 cycles during a data load, then a new inst request arrives → grant stays with data, mem_req_addr is stable all 5 cycles, inst_req_ready = 0 throughout.
6. rst asserted while in RESP → next cycle FSM = IDLE, all valids 0, starve_cnt = 0; a subsequent fetch behaves as in case 1.
